// File: rtl/exc_sched_pkg.sv
// Shared definitions for the exception sequencer: CP0 cause codes, MEM-stage
// exception flag bit positions and the sequencer FSM state encoding.
package exc_sched_pkg;

    localparam logic [4:0] EXC_CAUSE_INT  = 5'd0;
    localparam logic [4:0] EXC_CAUSE_ADEL = 5'd4;
    localparam logic [4:0] EXC_CAUSE_ADES = 5'd5;
    localparam logic [4:0] EXC_CAUSE_SYS  = 5'd8;
    localparam logic [4:0] EXC_CAUSE_BP   = 5'd9;
    localparam logic [4:0] EXC_CAUSE_RI   = 5'd10;
    localparam logic [4:0] EXC_CAUSE_OV   = 5'd12;
    localparam logic [4:0] EXC_CAUSE_NOP  = 5'h1F;

    localparam int FLAG_ADEL_IF = 0;
    localparam int FLAG_RI      = 1;
    localparam int FLAG_SYS     = 2;
    localparam int FLAG_BP      = 3;
    localparam int FLAG_OV      = 4;
    localparam int FLAG_ADEL_LD = 5;
    localparam int FLAG_ADES    = 6;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LSB = 10;
    localparam int STATUS_IM_MSB = 15;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_READY = 3'd1,
        ST_COMMIT     = 3'd2,
        ST_FLUSH      = 3'd3,
        ST_REDIRECT   = 3'd4
    } state_t;

endpackage

// File: rtl/exc_sched_if.sv
// Bundle of MEM-stage, CP0 and IF signals around the exception sequencer.
// Handshake: an event is taken only when i_mem_valid is high in IDLE; o_cp0_is_eret
// and o_redirect_valid are single-cycle strobes with no backpressure.
interface exc_sched_if;
    logic        i_mem_valid;
    logic [31:0] i_mem_pc;
    logic        i_mem_in_delay_slot;
    logic [6:0]  i_mem_exc_flags;
    logic        i_mem_is_eret;
    logic [5:0]  i_hw_int;
    logic        i_timer_int;
    logic [31:0] i_status;
    logic [31:0] i_epc;
    logic        i_pipe_ready;
    logic [4:0]  o_cp0_except_cause;
    logic [5:0]  o_cp0_int;
    logic [31:0] o_cp0_current_pc;
    logic        o_cp0_in_delay_slot;
    logic        o_cp0_is_eret;
    logic        o_stall_if;
    logic        o_flush;
    logic        o_redirect_valid;
    logic [31:0] o_redirect_pc;
    logic        o_busy;

    // master: pipeline/CP0 environment side
    modport master (
        output i_mem_valid, i_mem_pc, i_mem_in_delay_slot, i_mem_exc_flags, i_mem_is_eret,
               i_hw_int, i_timer_int, i_status, i_epc, i_pipe_ready,
        input  o_cp0_except_cause, o_cp0_int, o_cp0_current_pc, o_cp0_in_delay_slot,
               o_cp0_is_eret, o_stall_if, o_flush, o_redirect_valid, o_redirect_pc, o_busy
    );

    // slave: the sequencer itself
    modport slave (
        input  i_mem_valid, i_mem_pc, i_mem_in_delay_slot, i_mem_exc_flags, i_mem_is_eret,
               i_hw_int, i_timer_int, i_status, i_epc, i_pipe_ready,
        output o_cp0_except_cause, o_cp0_int, o_cp0_current_pc, o_cp0_in_delay_slot,
               o_cp0_is_eret, o_stall_if, o_flush, o_redirect_valid, o_redirect_pc, o_busy
    );
endinterface

// File: rtl/exc_sched_int_sync.sv
// Multi-flop synchroniser for asynchronous interrupt lines, cleared by reset.
module exc_sched_int_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[STAGES-1];
endmodule

// File: rtl/exc_sched.sv
// Exception/interrupt sequencer: picks the highest-priority MEM-stage event, commits it
// to CP0 once the pipeline is quiet, holds flush for the drain period and redirects IF.
module exc_sched
    import exc_sched_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int          DRAIN_CYCLES = 2,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    exc_sched_if.slave bus,
    output state_t     o_dbg_state
);
    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    state_t      state_q, state_d;
    logic [4:0]  cause_q, cause_d;
    logic [31:0] pc_q, pc_d;
    logic        ds_q, ds_d;
    logic        eret_q, eret_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] redir_pc_q, redir_pc_d;

    logic [5:0]  hw_sync;
    logic [5:0]  cp0_int;
    logic        int_pend;
    logic        has_exc;
    logic        take_eret;
    logic [4:0]  evt_cause;
    logic        unused_status;

    exc_sched_int_sync #(
        .WIDTH  (6),
        .STAGES (SYNC_STAGES)
    ) u_int_sync (
        .clk   (clk),
        .reset (reset),
        .din   (bus.i_hw_int),
        .dout  (hw_sync)
    );

    // Timer shares line 5 with hw_int[5]; it already comes from CP0's clock domain.
    assign cp0_int  = {hw_sync[5] | bus.i_timer_int, hw_sync[4:0]};
    assign int_pend = (|(bus.i_status[STATUS_IM_MSB:STATUS_IM_LSB] & cp0_int))
                      & bus.i_status[STATUS_IE] & ~bus.i_status[STATUS_EXL];
    assign has_exc   = int_pend | (|bus.i_mem_exc_flags);
    assign take_eret = bus.i_mem_is_eret & ~has_exc;
    assign unused_status = ^{bus.i_status[31:16], bus.i_status[9:2]};

    always_comb begin
        evt_cause = EXC_CAUSE_NOP;
        if (int_pend)                               evt_cause = EXC_CAUSE_INT;
        else if (bus.i_mem_exc_flags[FLAG_ADEL_IF]) evt_cause = EXC_CAUSE_ADEL;
        else if (bus.i_mem_exc_flags[FLAG_RI])      evt_cause = EXC_CAUSE_RI;
        else if (bus.i_mem_exc_flags[FLAG_SYS])     evt_cause = EXC_CAUSE_SYS;
        else if (bus.i_mem_exc_flags[FLAG_BP])      evt_cause = EXC_CAUSE_BP;
        else if (bus.i_mem_exc_flags[FLAG_OV])      evt_cause = EXC_CAUSE_OV;
        else if (bus.i_mem_exc_flags[FLAG_ADEL_LD]) evt_cause = EXC_CAUSE_ADEL;
        else if (bus.i_mem_exc_flags[FLAG_ADES])    evt_cause = EXC_CAUSE_ADES;
    end

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        pc_d       = pc_q;
        ds_d       = ds_q;
        eret_d     = eret_q;
        cnt_d      = cnt_q;
        redir_pc_d = redir_pc_q;

        bus.o_cp0_except_cause  = EXC_CAUSE_NOP;
        bus.o_cp0_current_pc    = 32'h0;
        bus.o_cp0_in_delay_slot = 1'b0;
        bus.o_cp0_is_eret       = 1'b0;
        bus.o_stall_if          = 1'b0;
        bus.o_flush             = 1'b0;
        bus.o_redirect_valid    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_mem_valid && (has_exc || bus.i_mem_is_eret)) begin
                    cause_d = evt_cause;
                    pc_d    = bus.i_mem_pc;
                    ds_d    = bus.i_mem_in_delay_slot;
                    eret_d  = take_eret;
                    state_d = bus.i_pipe_ready ? ST_COMMIT : ST_WAIT_READY;
                end
            end
            ST_WAIT_READY: begin
                bus.o_stall_if = 1'b1;
                if (bus.i_pipe_ready) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                bus.o_cp0_except_cause  = eret_q ? EXC_CAUSE_NOP : cause_q;
                bus.o_cp0_current_pc    = pc_q;
                bus.o_cp0_in_delay_slot = ds_q;
                bus.o_cp0_is_eret       = eret_q;
                bus.o_flush             = 1'b1;
                // EPC is sampled here, after CP0 has seen any earlier writes.
                redir_pc_d = eret_q ? bus.i_epc : EXC_VECTOR;
                cnt_d      = DRAIN_LOAD;
                state_d    = (DRAIN_CYCLES == 1) ? ST_REDIRECT : ST_FLUSH;
            end
            ST_FLUSH: begin
                bus.o_flush = 1'b1;
                if (cnt_q <= 3'd1) state_d = ST_REDIRECT;
                else               cnt_d   = cnt_q - 3'd1;
            end
            ST_REDIRECT: begin
                bus.o_redirect_valid = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cause_q    <= EXC_CAUSE_NOP;
            pc_q       <= 32'h0;
            ds_q       <= 1'b0;
            eret_q     <= 1'b0;
            cnt_q      <= 3'd0;
            redir_pc_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            pc_q       <= pc_d;
            ds_q       <= ds_d;
            eret_q     <= eret_d;
            cnt_q      <= cnt_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    assign bus.o_cp0_int     = cp0_int;
    assign bus.o_redirect_pc = redir_pc_q;
    assign bus.o_busy        = (state_q != ST_IDLE);
    assign o_dbg_state       = state_q;
endmodule
